boron_sbox_seq: RTL and testbench

BORON_SBOX_SEQ -- requirements
Module: boron_sbox_seq

---
 rtl/boron_pkg.sv | 20 ++
 rtl/boron_sbox_seq_sbox.sv | 11 +
 rtl/boron_sbox_seq.sv | 97 +++++++++
 tb/tb_boron_sbox_seq.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/boron_pkg.sv
// Shared BORON definitions: block width, round-FSM states and the 4-bit S-box table.
package boron_pkg;

    localparam int BLOCK_W = 64;
    localparam int NIBBLES = BLOCK_W / 4;

    // Nibble i of this constant (bits 4i+3:4i) is the S-box image of i.
    localparam logic [63:0] SBOX_TABLE = 64'h6358F02DAC971B4E;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } sbox_state_t;

    function automatic logic [3:0] sbox_lookup(input logic [3:0] nib);
        return SBOX_TABLE[{nib, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/boron_sbox_seq_sbox.sv
// Combinational BORON S-box cell: one nibble in, its substituted image out.
module S_Box
    import boron_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = sbox_lookup(i_nib);

endmodule

// File: rtl/boron_sbox_seq.sv
// BORON key-add + S-box layer, substituting LANES nibbles per cycle over 16/LANES cycles.
module boron_sbox_seq
    import boron_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] state_i,
    input  logic [BLOCK_W-1:0] rkey_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] state_o,
    output logic               busy
);

    localparam int GROUPS = NIBBLES / LANES;
    localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(GROUPS - 1);

    sbox_state_t        r_state;
    sbox_state_t        w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [BLOCK_W-1:0] r_work;
    logic [BLOCK_W-1:0] w_work_next;
    logic [5:0]         w_bit_base;
    logic [3:0]         w_lane_in  [LANES];
    logic [3:0]         w_lane_out [LANES];

    // Bit offset of the lowest nibble in the group being substituted this cycle.
    assign w_bit_base = 6'(int'(r_cnt) * LANES * 4);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_lane_in[gi] = r_work[w_bit_base + 6'(4 * gi) +: 4];

        S_Box u_sbox (
            .i_nib (w_lane_in[gi]),
            .o_nib (w_lane_out[gi])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_work  <= w_work_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_work_next  = r_work;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_work_next  = state_i ^ rkey_i;
                    w_cnt_next   = '0;
                    w_state_next = ST_SUB;
                end
            end
            ST_SUB: begin
                for (int li = 0; li < LANES; li++) begin
                    w_work_next[w_bit_base + 6'(4 * li) +: 4] = w_lane_out[li];
                end
                if (r_cnt == LAST_GRP) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_DONE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                // Returning to IDLE first keeps a new accept off the handshake edge.
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign state_o   = r_work;

endmodule

// File: tb/tb_boron_sbox_seq.sv
// Directed bench for boron_sbox_seq at LANES = 1, 4 and 16 with hand-computed vectors.
module tb_boron_sbox_seq;

    localparam int LANE_CFG [3] = '{1, 4, 16};

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_a  [3];
    logic        in_ready_a  [3];
    logic        out_valid_a [3];
    logic        out_ready_a [3];
    logic        busy_a      [3];
    logic [63:0] state_i_a   [3];
    logic [63:0] rkey_i_a    [3];
    logic [63:0] state_o_a   [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        boron_sbox_seq #(.LANES(LANE_CFG[gi])) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_a[gi]),
            .in_ready  (in_ready_a[gi]),
            .state_i   (state_i_a[gi]),
            .rkey_i    (rkey_i_a[gi]),
            .out_valid (out_valid_a[gi]),
            .out_ready (out_ready_a[gi]),
            .state_o   (state_o_a[gi]),
            .busy      (busy_a[gi])
        );
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_out(input int idx, output int cyc);
        cyc = 0;
        while (!out_valid_a[idx] && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_block(input int idx, input logic [63:0] s, input logic [63:0] k,
                             input logic [63:0] exp, input bit hold_ready);
        int cyc;
        int lat_exp;
        lat_exp = 16 / LANE_CFG[idx];
        @(negedge clk);
        check_eq("in_ready_idle", 64'(in_ready_a[idx]), 64'd1);
        in_valid_a[idx]  = 1'b1;
        state_i_a[idx]   = s;
        rkey_i_a[idx]    = k;
        out_ready_a[idx] = hold_ready;
        @(posedge clk);
        #1;
        in_valid_a[idx] = 1'b0;
        check_eq("busy_after_accept", 64'(busy_a[idx]), 64'd1);
        wait_out(idx, cyc);
        check_eq("latency", 64'(cyc), 64'(lat_exp));
        check_eq("state_o", state_o_a[idx], exp);
        $display("txn lanes=%0d state_i=%h rkey_i=%h state_o=%h latency=%0d",
                 LANE_CFG[idx], s, k, state_o_a[idx], cyc);
        out_ready_a[idx] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_a[idx] = 1'b0;
        check_eq("out_valid_drop", 64'(out_valid_a[idx]), 64'd0);
        check_eq("in_ready_back", 64'(in_ready_a[idx]), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid_a[i]  = 1'b0;
            out_ready_a[i] = 1'b0;
            state_i_a[i]   = '0;
            rkey_i_a[i]    = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_in_ready", 64'(in_ready_a[i]), 64'd1);
            check_eq("rst_busy", 64'(busy_a[i]), 64'd0);
            check_eq("rst_out_valid", 64'(out_valid_a[i]), 64'd0);
            check_eq("rst_state_o", state_o_a[i], 64'd0);
        end

        run_block(0, 64'h0, 64'h0, 64'hEEEEEEEEEEEEEEEE, 1'b0);
        run_block(0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h6666666666666666, 1'b0);
        run_block(0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h6666666666666666, 1'b0);
        run_block(0, 64'h0123456789ABCDEF, 64'h0, 64'hE4B179CAD20F8536, 1'b0);
        run_block(0, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 64'hEEEEEEEEEEEEEEEE, 1'b0);
        run_block(1, 64'h0123456789ABCDEF, 64'h0, 64'hE4B179CAD20F8536, 1'b0);
        run_block(1, 64'hFEDCBA9876543210, 64'h0, 64'h6358F02DAC971B4E, 1'b1);
        run_block(2, 64'h0123456789ABCDEF, 64'h0, 64'hE4B179CAD20F8536, 1'b0);
        run_block(2, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h6666666666666666, 1'b1);

        // Downstream stalls in DONE while upstream keeps offering the next block.
        @(negedge clk);
        in_valid_a[0]  = 1'b1;
        state_i_a[0]   = 64'h0123456789ABCDEF;
        rkey_i_a[0]    = 64'h0;
        out_ready_a[0] = 1'b0;
        @(posedge clk);
        #1;
        state_i_a[0] = 64'hFEDCBA9876543210;
        repeat (16) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_out_valid", 64'(out_valid_a[0]), 64'd1);
            check_eq("stall_state_o", state_o_a[0], 64'hE4B179CAD20F8536);
            check_eq("stall_in_ready", 64'(in_ready_a[0]), 64'd0);
            @(posedge clk);
            #1;
        end
        out_ready_a[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_a[0] = 1'b0;
        check_eq("hs_in_ready", 64'(in_ready_a[0]), 64'd1);
        check_eq("hs_busy", 64'(busy_a[0]), 64'd0);
        @(posedge clk);
        #1;
        in_valid_a[0] = 1'b0;
        check_eq("second_accept_busy", 64'(busy_a[0]), 64'd1);
        wait_out(0, cyc);
        check_eq("second_latency", 64'(cyc), 64'd16);
        check_eq("second_state_o", state_o_a[0], 64'h6358F02DAC971B4E);
        $display("txn lanes=1 stalled pair second state_o=%h latency=%0d", state_o_a[0], cyc);
        out_ready_a[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_a[0] = 1'b0;

        // Reset in the middle of substitution discards the block.
        @(negedge clk);
        in_valid_a[0] = 1'b1;
        state_i_a[0]  = 64'h0123456789ABCDEF;
        rkey_i_a[0]   = 64'h0;
        @(posedge clk);
        #1;
        in_valid_a[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("midrst_busy", 64'(busy_a[0]), 64'd0);
        check_eq("midrst_out_valid", 64'(out_valid_a[0]), 64'd0);
        check_eq("midrst_in_ready", 64'(in_ready_a[0]), 64'd1);
        check_eq("midrst_state_o", state_o_a[0], 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_eq("midrst_no_output", 64'(out_valid_a[0]), 64'd0);
        $display("txn lanes=1 reset mid-SUB busy=%0d out_valid=%0d", busy_a[0], out_valid_a[0]);
        run_block(0, 64'h0123456789ABCDEF, 64'h0, 64'hE4B179CAD20F8536, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
